// File: rtl/saturation_ctrl_pkg.sv
// Shared imager definitions for the saturation control block: pixel-stream
// dtype codes (as macros, used in port widths) and the controller state encodings.
// Latency: n/a (definitions only). Backpressure: n/a.
//
// Optional feature macro: SATURATION_CTRL_RAMP_EN (adds the RAMP state).
`ifndef SATURATION_CTRL_PKG_SV
`define SATURATION_CTRL_PKG_SV

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH       4
`define DTYPE_PIXEL       4'h0
`define DTYPE_FRAME_START 4'h1
`define DTYPE_LINE_START  4'h2
`define DTYPE_LINE_END    4'h3
`define DTYPE_FRAME_END   4'h4
`endif

package saturation_ctrl_pkg;

    // Controller state encodings. RAMP is only reachable when the ramp
    // feature is compiled in; its code stays reserved otherwise.
    localparam logic [1:0] SAT_ST_IDLE  = 2'd0;
    localparam logic [1:0] SAT_ST_ARMED = 2'd1;
    localparam logic [1:0] SAT_ST_RAMP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = SAT_ST_IDLE,
`ifdef SATURATION_CTRL_RAMP_EN
        ST_RAMP  = SAT_ST_RAMP,
`endif
        ST_ARMED = SAT_ST_ARMED
    } sat_state_e;

    // A frame boundary is a valid beat carrying the frame-end dtype.
    function automatic logic sat_is_frame_end(input logic                    dv,
                                              input logic [`DTYPE_WIDTH-1:0] dt);
        return dv && (dt == `DTYPE_FRAME_END);
    endfunction

endpackage

`endif

// File: rtl/saturation_ctrl_ramp_step.sv
// saturation_ramp_step: one per-frame strength update toward a target.
// Latency: combinational. Backpressure: none.
// Ports: cur/target/step (W bits) in; next (W bits) and done out.
//   done = step is zero (jump) or target is within one step of cur.
//   next = target when done, else cur moved by exactly step toward target.
module saturation_ramp_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] target,
    input  logic [W-1:0] step,
    output logic [W-1:0] next,
    output logic         done
);

    // One extra bit so differences and sums never wrap silently.
    logic [W:0] w_cur;
    logic [W:0] w_tgt;
    logic [W:0] w_step;
    logic [W:0] w_diff;
    logic [W:0] w_sum;
    logic       w_up;

    always_comb begin
        w_cur  = {1'b0, cur};
        w_tgt  = {1'b0, target};
        w_step = {1'b0, step};
        w_up   = (w_tgt > w_cur);
        w_diff = w_up ? (w_tgt - w_cur) : (w_cur - w_tgt);
        done   = (w_step == '0) || (w_diff <= w_step);

        if (done) begin
            w_sum = w_tgt;
        end else if (w_up) begin
            w_sum = w_cur + w_step;
        end else begin
            w_sum = w_cur - w_step;
        end

        // When not done the move stays strictly inside [cur, target], so the
        // top bit is never set; the clamp only pins the range by construction.
        if (w_sum[W]) begin
            next = w_up ? {W{1'b1}} : '0;
        end else begin
            next = w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/saturation_ctrl.sv
// saturation_ctrl: frame-synchronous update of saturation enable/strength.
// Latency: outputs change one cycle after a frame_end beat; config latched in one cycle.
// Backpressure: none; the pixel stream is only observed and cfg_we is always accepted.
//
// Ports:
//   clk, resetb          clock, async active-low reset
//   dvi, dtypei          pixel-stream valid and data type (frame_end detection)
//   cfg_we               write strobe latching cfg_enable/cfg_strength/cfg_step
//   enable, strength     registered controls to the saturation datapath
//   busy                 registered, high while a change is pending or ramping
//
// Optional macro SATURATION_CTRL_RAMP_EN: per-frame ramp limited by cfg_step.
// Without it cfg_step is ignored and every update jumps straight to target.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH       4
`define DTYPE_PIXEL       4'h0
`define DTYPE_FRAME_START 4'h1
`define DTYPE_LINE_START  4'h2
`define DTYPE_LINE_END    4'h3
`define DTYPE_FRAME_END   4'h4
`endif

module saturation_ctrl
    import saturation_ctrl_pkg::*;
#(
    parameter int STRENGTH_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      resetb,
    input  logic                      dvi,
    input  logic [`DTYPE_WIDTH-1:0]   dtypei,
    input  logic                      cfg_we,
    input  logic                      cfg_enable,
    input  logic [STRENGTH_WIDTH-1:0] cfg_strength,
    input  logic [STRENGTH_WIDTH-1:0] cfg_step,
    output logic                      enable,
    output logic [STRENGTH_WIDTH-1:0] strength,
    output logic                      busy
);

    sat_state_e                r_state;
    logic                      r_enable;
    logic [STRENGTH_WIDTH-1:0] r_strength;
    logic                      r_busy;
    logic [STRENGTH_WIDTH-1:0] r_target;
    logic                      r_pend_en;

    logic                      w_frame_end;
    logic [STRENGTH_WIDTH-1:0] w_step;
    logic [STRENGTH_WIDTH-1:0] w_next;
    logic                      w_done;

    assign w_frame_end = sat_is_frame_end(dvi, dtypei);

`ifdef SATURATION_CTRL_RAMP_EN
    logic [STRENGTH_WIDTH-1:0] r_step;
    assign w_step = r_step;
`else
    // A zero step makes the update a plain jump to target.
    logic w_unused_step;
    assign w_step        = '0;
    assign w_unused_step = ^cfg_step;
`endif

    // Update uses the latched (pre-write) target/step, so a write arriving on
    // the frame_end beat only takes effect at the following boundary.
    saturation_ramp_step #(
        .W      (STRENGTH_WIDTH)
    ) u_ramp_step (
        .cur    (r_strength),
        .target (r_target),
        .step   (w_step),
        .next   (w_next),
        .done   (w_done)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state    <= ST_IDLE;
            r_enable   <= 1'b0;
            r_strength <= '0;
            r_busy     <= 1'b0;
            r_target   <= '0;
            r_pend_en  <= 1'b0;
`ifdef SATURATION_CTRL_RAMP_EN
            r_step     <= '0;
`endif
        end else begin
            if (cfg_we) begin
                r_target  <= cfg_strength;
                r_pend_en <= cfg_enable;
`ifdef SATURATION_CTRL_RAMP_EN
                r_step    <= cfg_step;
`endif
            end

            case (r_state)
                ST_IDLE: begin
                    // A bare frame_end in IDLE leaves everything untouched.
                    if (cfg_we) begin
                        r_state <= ST_ARMED;
                        r_busy  <= 1'b1;
                    end
                end

                ST_ARMED: begin
                    if (w_frame_end) begin
                        r_enable   <= r_pend_en;
                        r_strength <= w_next;
                        if (cfg_we) begin
                            // New write lands on the boundary: re-arm for it.
                            r_state <= ST_ARMED;
                            r_busy  <= 1'b1;
                        end else if (w_done) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
`ifdef SATURATION_CTRL_RAMP_EN
                        else begin
                            r_state <= ST_RAMP;
                            r_busy  <= 1'b1;
                        end
`endif
                    end
                end

`ifdef SATURATION_CTRL_RAMP_EN
                ST_RAMP: begin
                    // enable was already applied on entry; only strength moves.
                    // A write here just retargets the ramp in progress.
                    if (w_frame_end) begin
                        r_strength <= w_next;
                        if (cfg_we || !w_done) begin
                            r_state <= ST_RAMP;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
`endif

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign enable   = r_enable;
    assign strength = r_strength;
    assign busy     = r_busy;

endmodule

// File: tb/tb_saturation_ctrl.sv
// Bench for saturation_ctrl: table of per-cycle stimulus with expected outputs
// after the following clock edge, queued as a scoreboard and checked one cycle later,
// plus hand sequences around asynchronous reset.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH       4
`define DTYPE_PIXEL       4'h0
`define DTYPE_FRAME_START 4'h1
`define DTYPE_LINE_START  4'h2
`define DTYPE_LINE_END    4'h3
`define DTYPE_FRAME_END   4'h4
`endif

module tb_saturation_ctrl;

    localparam int SW = 8;

    logic                    clk = 1'b0;
    logic                    resetb;
    logic                    dvi;
    logic [`DTYPE_WIDTH-1:0] dtypei;
    logic                    cfg_we;
    logic                    cfg_enable;
    logic [SW-1:0]           cfg_strength;
    logic [SW-1:0]           cfg_step;
    logic                    enable;
    logic [SW-1:0]           strength;
    logic                    busy;

    int total = 0;
    int bad   = 0;

    saturation_ctrl #(
        .STRENGTH_WIDTH (SW)
    ) dut (
        .clk          (clk),
        .resetb       (resetb),
        .dvi          (dvi),
        .dtypei       (dtypei),
        .cfg_we       (cfg_we),
        .cfg_enable   (cfg_enable),
        .cfg_strength (cfg_strength),
        .cfg_step     (cfg_step),
        .enable       (enable),
        .strength     (strength),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // kind: 0 idle, 1 frame_end, 2 frame_end dtype with dvi low, 3 valid pixel
    typedef struct {
        logic          we;
        logic          en;
        logic [SW-1:0] str;
        logic [SW-1:0] stp;
        int            kind;
        logic          x_en;
        logic [SW-1:0] x_str;
        logic          x_busy;
        string         name;
    } vec_t;

    typedef struct {
        logic          en;
        logic [SW-1:0] str;
        logic          busy;
        string         name;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic vec_t mk(input logic we, input logic en, input logic [SW-1:0] str,
                                input logic [SW-1:0] stp, input int kind, input logic x_en,
                                input logic [SW-1:0] x_str, input logic x_busy, input string name);
        vec_t v;
        v.we = we; v.en = en; v.str = str; v.stp = stp; v.kind = kind;
        v.x_en = x_en; v.x_str = x_str; v.x_busy = x_busy; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_now(input string name, input logic x_en, input logic [SW-1:0] x_str,
                             input logic x_busy);
        chk({name, "_enable"}, {{(SW-1){1'b0}}, enable}, {{(SW-1){1'b0}}, x_en});
        chk({name, "_strength"}, strength, x_str);
        chk({name, "_busy"}, {{(SW-1){1'b0}}, busy}, {{(SW-1){1'b0}}, x_busy});
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty actual=none required=entry");
        end else begin
            e = exp_q.pop_front();
            check_now(e.name, e.en, e.str, e.busy);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge, queue its expectation,
    // then compare just after the rising edge that consumes it.
    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        cfg_we       = v.we;
        cfg_enable   = v.en;
        cfg_strength = v.str;
        cfg_step     = v.stp;
        case (v.kind)
            1:       begin dvi = 1'b1; dtypei = `DTYPE_FRAME_END; end
            2:       begin dvi = 1'b0; dtypei = `DTYPE_FRAME_END; end
            3:       begin dvi = 1'b1; dtypei = `DTYPE_PIXEL;     end
            default: begin dvi = 1'b0; dtypei = `DTYPE_PIXEL;     end
        endcase
        e.en = v.x_en; e.str = v.x_str; e.busy = v.x_busy; e.name = v.name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
        cfg_we = 1'b0;
        dvi    = 1'b0;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        resetb = 1'b0;
        #1;
        check_now(name, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        resetb = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb = 1'b0; dvi = 1'b0; dtypei = `DTYPE_PIXEL;
        cfg_we = 1'b0; cfg_enable = 1'b0; cfg_strength = '0; cfg_step = '0;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_hold", 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        resetb = 1'b1;

        // Jump behaviour shared by both builds (step 0 always jumps).
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, "idle_fe"));
        tbl.push_back(mk(1, 1, 8'h80, 8'h00, 0, 0, 8'h00, 1, "arm80"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 3, 0, 8'h00, 1, "midframe_pixel"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 2, 0, 8'h00, 1, "fe_dtype_no_dv"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h80, 0, "apply80"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h80, 0, "idle_fe2"));
        tbl.push_back(mk(1, 1, 8'h40, 8'h00, 0, 1, 8'h80, 1, "arm40"));
        tbl.push_back(mk(1, 0, 8'h90, 8'h00, 1, 1, 8'h40, 1, "simul_we_fe"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 8'h40, 1, "still_armed"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h90, 0, "apply90_dis"));
        tbl.push_back(mk(1, 1, 8'hFF, 8'h00, 0, 0, 8'h90, 1, "armFF"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 0, "applyFF"));
        tbl.push_back(mk(1, 1, 8'h00, 8'h00, 0, 1, 8'hFF, 1, "arm00"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 0, "apply00"));
`ifdef SATURATION_CTRL_RAMP_EN
        tbl.push_back(mk(1, 1, 8'h50, 8'h20, 0, 1, 8'h00, 1, "up_arm"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 1, "up_1"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 1, "up_2"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 3, 1, 8'h40, 1, "up_midframe"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h50, 0, "up_3"));
        tbl.push_back(mk(1, 1, 8'h10, 8'h00, 0, 1, 8'h50, 1, "to10_arm"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 0, "to10"));
        tbl.push_back(mk(1, 1, 8'h00, 8'h30, 0, 1, 8'h10, 1, "down_arm"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 0, "down_nowrap"));
        tbl.push_back(mk(1, 1, 8'h80, 8'h20, 0, 1, 8'h00, 1, "rt_arm"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 1, "rt_1"));
        tbl.push_back(mk(1, 1, 8'h10, 8'h08, 1, 1, 8'h40, 1, "rt_simul"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h38, 1, "rt_retarget"));
        tbl.push_back(mk(1, 1, 8'h30, 8'h00, 0, 1, 8'h38, 1, "rt_we_in_ramp"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 0, "rt_jump_done"));
        tbl.push_back(mk(1, 1, 8'hFF, 8'hF0, 0, 1, 8'h30, 1, "top_arm"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 0, "top_clamp"));
        tbl.push_back(mk(1, 1, 8'h05, 8'h40, 0, 1, 8'hFF, 1, "dn_arm"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'hBF, 1, "dn_1"));
`else
        tbl.push_back(mk(1, 1, 8'h50, 8'h20, 0, 1, 8'h00, 1, "step_ign_arm"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h50, 0, "step_ign_jump"));
        tbl.push_back(mk(1, 1, 8'h10, 8'h30, 0, 1, 8'h50, 1, "step_ign_arm2"));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 0, "step_ign_jump2"));
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
        end

        // Reset while ARMED abandons the pending write.
        do_reset("rst_clean");
        drive(mk(1, 1, 8'h60, 8'h00, 0, 0, 8'h00, 1, "rstA_arm"));
        do_reset("rst_armed");
        drive(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, "rstA_fe1"));
        drive(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, "rstA_fe2"));

`ifdef SATURATION_CTRL_RAMP_EN
        // Reset mid-ramp 0x20 -> 0xA0 after the first step.
        drive(mk(1, 1, 8'h20, 8'h00, 0, 0, 8'h00, 1, "rstR_arm20"));
        drive(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 0, "rstR_at20"));
        drive(mk(1, 1, 8'hA0, 8'h20, 0, 1, 8'h20, 1, "rstR_armA0"));
        drive(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 1, "rstR_step1"));
        do_reset("rst_ramp");
        drive(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, "rstR_fe1"));
        drive(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, "rstR_fe2"));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/saturation_ctrl.md
SATURATION_CTRL -- requirements
Module: saturation_ctrl

Interface
REQ-001 SHALL have parameter: STRENGTH_WIDTH, default 8, width of the strength word (unsigned, all fractional bits).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: resetb  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: dvi  input  1  pixel-stream data valid.
REQ-005 SHALL have port: dtypei  input  `DTYPE_WIDTH  pixel-stream data type.
REQ-006 SHALL have port: cfg_we  input  1  single-cycle write strobe.
REQ-007 SHALL have port: cfg_enable  input  1  requested saturation enable.
REQ-008 SHALL have port: cfg_strength  input  STRENGTH_WIDTH  requested target strength.
REQ-009 SHALL have port: cfg_step  input  STRENGTH_WIDTH  maximum strength change per frame (0 = jump).
REQ-010 SHALL have port: enable  output  1  enable to saturation datapath.
REQ-011 SHALL have port: strength  output  STRENGTH_WIDTH  strength to saturation datapath.
REQ-012 SHALL have port: busy  output  1  high while a change is pending or ramping.

Function
REQ-013 SHALL define frame_end as dvi && (dtypei == `DTYPE_FRAME_END); updates to enable/strength SHALL occur only on the clock edge after a frame_end beat, never mid-frame.
REQ-014 SHALL implement states IDLE, ARMED, RAMP; busy = (state != IDLE), registered.
REQ-015 cfg_we in any state SHALL latch cfg_strength into target, cfg_enable into pend_en, and cfg_step into step, all registered.
REQ-016 cfg_we in IDLE or ARMED SHALL move to ARMED. cfg_we in RAMP SHALL remain in RAMP, ramping toward the new target.
REQ-017 ARMED + frame_end SHALL set enable <= pend_en and apply one strength update per REQ-019/020.
REQ-018 RAMP + frame_end SHALL apply one strength update; enable is unchanged.
REQ-019 Update: if step == 0 or |target - strength| <= step, then strength <= target and next state IDLE. Otherwise strength moves by exactly step toward target and next state is RAMP.
REQ-020 Update arithmetic SHALL be done in STRENGTH_WIDTH+1 bits with no wrap. Result SHALL stay within [0, 2^STRENGTH_WIDTH-1].
REQ-021 Simultaneous cfg_we and frame_end: the boundary SHALL apply the previously latched values. The new write is then latched, and the next state is ARMED (from IDLE/ARMED) or RAMP (from RAMP).
REQ-022 IDLE + frame_end without cfg_we SHALL change nothing.
REQ-023 Latency: one cycle from the frame_end beat to the updated outputs.

Reset
REQ-024 Asserting resetb low SHALL immediately force: enable=0, strength=0, busy=0, target=0, pend_en=0, step=0, state=IDLE.
REQ-025 Reset during ARMED or RAMP SHALL abandon the pending change. After release, the block stays IDLE until the next cfg_we.

Configuration
REQ-026 Macro SATURATION_CTRL_RAMP_EN SHALL compile in the per-frame ramp.
REQ-027 Without SATURATION_CTRL_RAMP_EN: cfg_step is ignored, every update jumps to target, and the RAMP state and step register SHALL be absent.

Structure
REQ-028 State encodings (IDLE/ARMED/RAMP) SHALL be localparams in the shared imager defines include, alongside the dtype codes.
REQ-029 The ramp arithmetic of REQ-019/020 SHALL be a combinational sub-module saturation_ramp_step, with ports cur, target, step -> next, done.
REQ-030 The block SHALL be 120-400 lines of RTL excluding the sub-module.

Verification
REQ-031 Reset: hold resetb low, then release -> enable=0, strength=0, busy=0. A frame_end with no write -> no change.
REQ-032 No ramp: write en=1, strength=0x80 mid-frame -> busy=1 and outputs unchanged until frame_end. The cycle after frame_end -> enable=1, strength=0x80, busy=0.
REQ-033 RAMP_EN, up-ramp: strength=0x00, write 0x50, step=0x20 -> successive frame_ends give 0x20, 0x40, 0x50, with busy low after 0x50.
REQ-034 RAMP_EN, down-ramp near zero: strength=0x10, write 0x00, step=0x30 -> 0x00 in one frame, no wrap.
REQ-035 Simultaneous: ARMED with 0x40, then cfg_we=0x90 on the frame_end cycle -> strength=0x40, state ARMED. The next frame_end -> 0x90 (no ramp).
REQ-036 Mid-ramp reset: ramping 0x20 -> 0xA0, assert resetb after the first step -> all outputs 0, IDLE. Subsequent frame_ends -> no change.
